// File: rtl/mem_responder_pkg.sv
// Shared types for the snooping-bus memory responder: system sizes, bus and
// crossbar payloads, and the responder state encoding.
package mem_responder_pkg;

    localparam int unsigned NUM_CPUS       = 4;
    localparam int unsigned XLEN           = 8;
    localparam int unsigned CACHELINE_SIZE = 8;
    localparam int unsigned SRC_W          = 3;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [2:0] {
        BUS_IDLE  = 3'd0,
        BUS_RD    = 3'd1,
        BUS_RDX   = 3'd2,
        BUS_UPG   = 3'd3,
        BUS_FLUSH = 3'd4
    } bus_tx_t;

    typedef struct packed {
        logic             valid;
        logic [SRC_W-1:0] source;
        logic [XLEN-1:0]  addr;
        bus_tx_t          bus_tx;
    } bus_msg_t;

    typedef struct packed {
        logic                      valid;
        logic [SRC_W-1:0]          destination;
        logic [XLEN-1:0]           addr;
        logic [CACHELINE_SIZE-1:0] data;
    } xbar_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_MEM_WAIT,
        ST_RESPOND
    } resp_state_t;

    // One-hot of the requester's own snoop bit; sources outside the CPU range mask nothing.
    function automatic logic [NUM_CPUS-1:0] src_mask(input logic [SRC_W-1:0] src);
        src_mask = '0;
        if (32'(src) < NUM_CPUS)
            src_mask = NUM_CPUS'(1) << src;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Backing line store: synchronous write, combinational read, asynchronous clear.
module mem_array #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: takes bus reads the caches cannot supply, waits out the
// memory latency and returns the line over the crossbar; absorbs writebacks.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  bus_msg_t                  bus_req,
    output logic                      bus_ready,
    input  logic [CACHELINE_SIZE-1:0] flush_data,
    input  logic [NUM_CPUS-1:0]       snoop_hit,
    output xbar_msg_t                 xbar_out,
    input  logic                      xbar_ready
);

    resp_state_t               state;
    logic [CNT_W-1:0]          cnt;
    logic [SRC_W-1:0]          cap_src;
    logic [XLEN-1:0]           cap_addr;
    logic [CACHELINE_SIZE-1:0] mem_rdata;
    logic                      accept_c;
    logic                      mem_we_c;

    assign accept_c = bus_req.valid && bus_ready;
    assign mem_we_c = accept_c && (bus_req.bus_tx == BUS_FLUSH);

    mem_array #(
        .AW (XLEN),
        .DW (CACHELINE_SIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we_c),
        .waddr (bus_req.addr),
        .wdata (flush_data),
        .raddr (cap_addr),
        .rdata (mem_rdata)
    );

    // bus_ready tracks "next state is IDLE" so it is registered yet equal to state==IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bus_ready <= 1'b1;
            xbar_out  <= '0;
            cnt       <= '0;
            cap_src   <= '0;
            cap_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c && (bus_req.bus_tx == BUS_RD || bus_req.bus_tx == BUS_RDX)) begin
                        cap_src   <= bus_req.source;
                        cap_addr  <= bus_req.addr;
                        state     <= ST_SNOOP;
                        bus_ready <= 1'b0;
                    end
                end
                ST_SNOOP: begin
                    if (|(snoop_hit & ~src_mask(cap_src))) begin
                        state     <= ST_IDLE;
                        bus_ready <= 1'b1;
                    end else begin
                        cnt   <= CNT_W'(MEM_LATENCY - 1);
                        state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (cnt == '0) begin
                        xbar_out <= '{valid: 1'b1, destination: cap_src,
                                      addr: cap_addr, data: mem_rdata};
                        state    <= ST_RESPOND;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESPOND: begin
                    if (xbar_ready) begin
                        xbar_out  <= '0;
                        state     <= ST_IDLE;
                        bus_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bus_ready <= 1'b1;
                    xbar_out  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed vector bench for mem_responder: table of single requests plus
// hand-written backpressure and mid-transaction reset sequences.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned LAT = 3;

    logic                      clk;
    logic                      rst_n;
    bus_msg_t                  bus_req;
    logic                      bus_ready;
    logic [CACHELINE_SIZE-1:0] flush_data;
    logic [NUM_CPUS-1:0]       snoop_hit;
    xbar_msg_t                 xbar_out;
    logic                      xbar_ready;

    int n_pass;
    int n_total;

    typedef struct {
        bus_tx_t    tx;
        logic [2:0] src;
        logic [7:0] addr;
        logic [7:0] fdata;
        logic [3:0] hit;
        logic       resp;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [11];

    mem_responder #(.MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_req    (bus_req),
        .bus_ready  (bus_ready),
        .flush_data (flush_data),
        .snoop_hit  (snoop_hit),
        .xbar_out   (xbar_out),
        .xbar_ready (xbar_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request in IDLE, then watch 12 cycles after the accepting edge.
    // k=0 is the cycle right after acceptance; a response is expected at k=LAT+1.
    task automatic run_vec(input vec_t v, input string tag);
        int         first_v;
        int         first_r;
        int         exp_r;
        logic       zero_bad;
        logic [7:0] got_data;
        logic [7:0] got_addr;
        logic [2:0] got_dst;
        first_v  = -1;
        first_r  = -1;
        zero_bad = 1'b0;
        got_data = '0;
        got_addr = '0;
        got_dst  = '0;
        bus_req    = '{valid: 1'b1, source: v.src, addr: v.addr, bus_tx: v.tx};
        flush_data = v.fdata;
        snoop_hit  = v.hit;
        xbar_ready = 1'b1;
        chk({tag, "_ready_pre"}, 32'(bus_ready), 32'd1);
        tick();
        bus_req    = '0;
        flush_data = '0;
        for (int k = 0; k < 12; k++) begin
            if (xbar_out.valid && first_v < 0) begin
                first_v  = k;
                got_data = xbar_out.data;
                got_addr = xbar_out.addr;
                got_dst  = xbar_out.destination;
            end
            if (bus_ready && first_r < 0) first_r = k;
            if (!xbar_out.valid && xbar_out != '0) zero_bad = 1'b1;
            tick();
        end
        snoop_hit = '0;
        if (v.resp) exp_r = int'(LAT) + 2;
        else if (v.tx == BUS_RD || v.tx == BUS_RDX) exp_r = 1;
        else exp_r = 0;
        chk({tag, "_resp"}, 32'(first_v >= 0), 32'(v.resp));
        if (v.resp) begin
            chk({tag, "_latency"}, 32'(first_v), 32'(LAT + 1));
            chk({tag, "_dest"}, 32'(got_dst), 32'(v.src));
            chk({tag, "_addr"}, 32'(got_addr), 32'(v.addr));
            chk({tag, "_data"}, 32'(got_data), 32'(v.data));
        end
        chk({tag, "_ready_ret"}, 32'(first_r), 32'(exp_r));
        chk({tag, "_zero_idle"}, 32'(zero_bad), 32'd0);
    endtask

    initial begin
        int   waited;
        logic bad;
        vec_t v;
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{BUS_FLUSH, 3'd0, 8'h05, 8'hA5, 4'b0000, 1'b0, 8'h00};
        vecs[1]  = '{BUS_RD,    3'd2, 8'h05, 8'h00, 4'b0000, 1'b1, 8'hA5};
        vecs[2]  = '{BUS_RDX,   3'd1, 8'h12, 8'h00, 4'b0100, 1'b0, 8'h00};
        vecs[3]  = '{BUS_RD,    3'd3, 8'h05, 8'h00, 4'b1000, 1'b1, 8'hA5};
        vecs[4]  = '{BUS_UPG,   3'd1, 8'h07, 8'hFF, 4'b0000, 1'b0, 8'h00};
        vecs[5]  = '{BUS_RD,    3'd0, 8'h07, 8'h00, 4'b0000, 1'b1, 8'h00};
        vecs[6]  = '{BUS_FLUSH, 3'd0, 8'h12, 8'h3C, 4'b0000, 1'b0, 8'h00};
        vecs[7]  = '{BUS_RD,    3'd6, 8'h12, 8'h00, 4'b0001, 1'b0, 8'h00};
        vecs[8]  = '{BUS_RDX,   3'd0, 8'h12, 8'h00, 4'b0001, 1'b1, 8'h3C};
        vecs[9]  = '{BUS_IDLE,  3'd2, 8'h05, 8'h77, 4'b0000, 1'b0, 8'h00};
        vecs[10] = '{BUS_RD,    3'd4, 8'h12, 8'h00, 4'b0000, 1'b1, 8'h3C};

        rst_n      = 1'b0;
        bus_req    = '0;
        flush_data = '0;
        snoop_hit  = '0;
        xbar_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("reset_ready", 32'(bus_ready), 32'd1);
        chk("reset_xbar_valid", 32'(xbar_out.valid), 32'd0);
        chk("reset_xbar_zero", 32'(xbar_out == '0), 32'd1);

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: response held 4 stalled cycles while a Flush to the same line waits.
        bus_req    = '{valid: 1'b1, source: 3'd2, addr: 8'h05, bus_tx: BUS_RD};
        xbar_ready = 1'b0;
        tick();
        bus_req    = '{valid: 1'b1, source: 3'd0, addr: 8'h05, bus_tx: BUS_FLUSH};
        flush_data = 8'h11;
        waited = 0;
        while (!xbar_out.valid && waited < 20) begin
            tick();
            waited++;
        end
        chk("bp_wait", 32'(waited < 20), 32'd1);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!xbar_out.valid || xbar_out.destination != 3'd2 || xbar_out.addr != 8'h05
                || xbar_out.data != 8'hA5 || bus_ready) bad = 1'b1;
            tick();
        end
        chk("bp_held", 32'(bad), 32'd0);
        chk("bp_data", 32'(xbar_out.data), 32'hA5);
        chk("bp_ready_low", 32'(bus_ready), 32'd0);
        xbar_ready = 1'b1;
        tick();
        chk("bp_valid_drop", 32'(xbar_out.valid), 32'd0);
        chk("bp_ready_back", 32'(bus_ready), 32'd1);
        tick();
        bus_req    = '0;
        flush_data = '0;
        v = '{BUS_RD, 3'd1, 8'h05, 8'h00, 4'b0000, 1'b1, 8'h11};
        run_vec(v, "after_flush");

        // Reset pulse during MEM_WAIT abandons the read and clears memory.
        bus_req = '{valid: 1'b1, source: 3'd1, addr: 8'h05, bus_tx: BUS_RD};
        tick();
        bus_req = '0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_xbar", 32'(xbar_out == '0), 32'd1);
        chk("rst_mid_ready", 32'(bus_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (xbar_out.valid || !bus_ready) bad = 1'b1;
            tick();
        end
        chk("rst_mid_no_resp", 32'(bad), 32'd0);
        v = '{BUS_RD, 3'd2, 8'h05, 8'h00, 4'b0000, 1'b1, 8'h00};
        run_vec(v, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 3, memory read latency in cycles (legal 1..15).
REQ-002 SHALL take NUM_CPUS, XLEN and CACHELINE_SIZE from the shared types package; no local redefinition.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 bus_req  input  bus_msg_t  snooping-bus request (valid, source, addr, bus_tx).
REQ-006 bus_ready  output  1  responder can accept bus_req this cycle.
REQ-007 flush_data  input  CACHELINE_SIZE  writeback data, qualified by accepted Bus_Flush.
REQ-008 snoop_hit  input  NUM_CPUS  bit i = cache i holds line in M/E and supplies data itself.
REQ-009 xbar_out  output  xbar_msg_t  data response (valid, destination, addr, data).
REQ-010 xbar_ready  input  1  crossbar accepts xbar_out this cycle.

Function
REQ-011 SHALL hold backing memory of 2^XLEN lines, CACHELINE_SIZE bits each, indexed by full addr.
REQ-012 SHALL implement FSM states IDLE, SNOOP, MEM_WAIT, RESPOND.
REQ-013 bus_ready SHALL be 1 only in IDLE; a request is accepted when bus_req.valid && bus_ready.
REQ-014 Accepted Bus_Rd or Bus_Rdx: capture source, addr, bus_tx; IDLE -> SNOOP.
REQ-015 Accepted Bus_Flush: mem[addr] <= flush_data at that clock edge; remain IDLE; no xbar response.
REQ-016 Accepted Bus_Upg or Bus_Idle: no memory access, no response; remain IDLE.
REQ-017 SNOOP (exactly 1 cycle): evaluate snoop_hit with the captured source's bit masked off; any remaining bit set -> IDLE, no response; else -> MEM_WAIT with counter loaded to MEM_LATENCY-1.
REQ-018 Source values >= NUM_CPUS SHALL mask no snoop_hit bit.
REQ-019 MEM_WAIT: counter decrements each cycle; on counter==0 register xbar_out.data = mem[captured addr] and -> RESPOND.
REQ-020 RESPOND: xbar_out.valid=1, destination=captured source, addr=captured addr; all fields held stable until xbar_ready.
REQ-021 RESPOND with xbar_ready=1: -> IDLE next cycle; xbar_out.valid=0 in IDLE.
REQ-022 Latency: request accepted at edge T -> xbar_out.valid first high in cycle T+2+MEM_LATENCY (default: T+5).
REQ-023 Back-to-back: after handshake the next request is accepted no earlier than the following cycle; Flush after Rd to same addr is therefore ordered.
REQ-024 xbar_out fields SHALL be zero whenever xbar_out.valid=0.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, bus_ready=1 (once released), xbar_out all-zero, counter zero, memory cleared to zero.
REQ-026 Reset asserted mid-transaction SHALL abandon it; no response is issued after release.

Structure
REQ-027 Responder FSM state enum SHALL be added to the shared types package; MEM_LATENCY stays a module parameter.
REQ-028 Backing memory SHALL be a sub-module mem_array (sync write, combinational read, async clear).

Verification
REQ-029 Flush addr=0x05 data=0xA5, then Bus_Rd addr=0x05 source=2, snoop_hit=0 -> xbar valid at T+5, destination=2, data=0xA5.
REQ-030 Bus_Rdx addr=0x12 source=1, snoop_hit=4'b0100 -> no xbar valid; bus_ready high again after SNOOP.
REQ-031 Bus_Rd source=3, snoop_hit=4'b1000 (own bit only) -> response issued, data=mem[addr].
REQ-032 Response with xbar_ready low 4 cycles -> xbar_out held stable 4+ cycles; bus_ready=0 throughout.
REQ-033 rst_n pulsed low during MEM_WAIT -> no response; subsequent Bus_Rd of previously flushed addr returns 0x00.
REQ-034 Bus_Upg addr=0x07 -> no response; memory unchanged; bus_ready stays 1.
